// File: rtl/btn_event_ctrl_pkg.sv
// Shared types for the button event controller: event codes, per-button FSM states and id sizing.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_LONG    = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        HELD    = 2'b10
    } btn_state_t;

    // Button index width; a single button still gets a 1-bit id.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_event_ctrl_if.sv
// Event port between the button controller and the UI consumer (valid/ready handshake).
interface btn_event_ctrl_if
    import btn_evt_pkg::*;
#(
    parameter int unsigned NBTN = 4
) ();

    localparam int unsigned IDW = id_width(NBTN);

    logic           evt_valid_o;
    logic           evt_ready_i;
    logic [IDW-1:0] evt_id_o;
    logic [1:0]     evt_type_o;

    modport master (
        output evt_valid_o,
        output evt_id_o,
        output evt_type_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_id_o,
        input  evt_type_o,
        output evt_ready_i
    );

endinterface

// File: rtl/btn_event_ctrl_track.sv
// Per-button tracker: edge detect, press FSM, optional hold timer, 1-deep event slot and sticky overflow.
// Long-press support is built only when BTN_LONG_PRESS_EN is defined.
module btn_track
    import btn_evt_pkg::*;
`ifdef BTN_LONG_PRESS_EN
#(
    parameter int unsigned LONG_TICKS = 1000
)
`endif
(
    input  logic       sysclk,
    input  logic       reset,
    input  logic       btn,
`ifdef BTN_LONG_PRESS_EN
    input  logic       tick,
`endif
    input  logic       take,
    input  logic       ovf_clr,
    output logic       slot_full,
    output logic [1:0] slot_type,
    output logic       ovf
);

    logic       btn_prev;
    logic       rise;
    logic       fall;
    btn_state_t state;
    btn_state_t state_d;
    logic       post;
    logic [1:0] post_type;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HCW = $clog2(LONG_TICKS + 1);
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_cnt_d;
`endif

    assign rise = btn & ~btn_prev;
    assign fall = ~btn & btn_prev;

    // State register and level history
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            btn_prev <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_d;
            btn_prev <= btn;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt <= hold_cnt_d;
`endif
        end
    end

    // Next state and event posting; release always wins over a same-cycle tick
    always_comb begin
        state_d    = state;
        post       = 1'b0;
        post_type  = 2'b00;
`ifdef BTN_LONG_PRESS_EN
        hold_cnt_d = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d    = PRESSED;
                    post       = 1'b1;
                    post_type  = EVT_PRESS;
`ifdef BTN_LONG_PRESS_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d   = IDLE;
                    post      = 1'b1;
                    post_type = EVT_RELEASE;
                end
`ifdef BTN_LONG_PRESS_EN
                else if (tick) begin
                    hold_cnt_d = hold_cnt + HCW'(1);
                    if (hold_cnt == HCW'(LONG_TICKS - 1)) begin
                        state_d   = HELD;
                        post      = 1'b1;
                        post_type = EVT_LONG;
                    end
                end
`endif
            end
            HELD: begin
                if (fall) begin
                    state_d   = IDLE;
                    post      = 1'b1;
                    post_type = EVT_RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot accepts a new event when empty or being drained this cycle; otherwise flag overflow
    always_ff @(posedge sysclk) begin
        if (reset) begin
            slot_full <= 1'b0;
            slot_type <= 2'b00;
            ovf       <= 1'b0;
        end else begin
            if (post && (!slot_full || take)) begin
                slot_full <= 1'b1;
                slot_type <= post_type;
            end else if (take) begin
                slot_full <= 1'b0;
            end
            if (ovf_clr) begin
                ovf <= 1'b0;
            end else if (post && slot_full && !take) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: per-button trackers, shared hold-time prescaler, round-robin arbiter, output register.
// Define BTN_LONG_PRESS_EN to build the LONG event path (tick prescaler, hold counters, HELD state).
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned NBTN       = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned LONG_TICKS = 1000
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic [NBTN-1:0]     btn_i,
    btn_event_ctrl_if.master    evt,
    output logic [NBTN-1:0]     ovf_o,
    input  logic                ovf_clr_i
);

    localparam int unsigned IDW    = id_width(NBTN);
    localparam bit          CFG_OK = (NBTN >= 1) && (NBTN <= 16) && (TICK_DIV >= 2) && (LONG_TICKS >= 1);

    if (!CFG_OK) begin : g_cfg_err
        $error("btn_event_ctrl: parameter out of range");
    end

    logic [NBTN-1:0] slot_full;
    logic [1:0]      slot_type [NBTN];
    logic [NBTN-1:0] take_c;

    logic            out_valid;
    logic [IDW-1:0]  out_id;
    logic [1:0]      out_type;
    logic [IDW-1:0]  rr_ptr;

    logic            out_free_c;
    logic            gnt_found_c;
    logic [IDW-1:0]  gnt_id_c;
    int unsigned     scan_idx;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned TDW = $clog2(TICK_DIV);
    logic [TDW-1:0] tick_cnt;
    logic           tick_c;

    assign tick_c = (tick_cnt == TDW'(TICK_DIV - 1));

    // Free-running hold-time prescaler shared by all buttons
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TDW'(1);
        end
    end
`endif

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        btn_track
`ifdef BTN_LONG_PRESS_EN
            #(.LONG_TICKS(LONG_TICKS))
`endif
        u_track (
            .sysclk    (sysclk),
            .reset     (reset),
            .btn       (btn_i[g]),
`ifdef BTN_LONG_PRESS_EN
            .tick      (tick_c),
`endif
            .take      (take_c[g]),
            .ovf_clr   (ovf_clr_i),
            .slot_full (slot_full[g]),
            .slot_type (slot_type[g]),
            .ovf       (ovf_o[g])
        );
    end

    assign out_free_c = !out_valid || evt.evt_ready_i;

    // First full slot at or after the round-robin pointer
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_id_c    = '0;
        scan_idx    = 0;
        for (int unsigned off = 0; off < NBTN; off++) begin
            scan_idx = 32'(rr_ptr) + off;
            if (scan_idx >= NBTN) begin
                scan_idx = scan_idx - NBTN;
            end
            if (!gnt_found_c && slot_full[IDW'(scan_idx)]) begin
                gnt_found_c = 1'b1;
                gnt_id_c    = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        take_c = '0;
        if (out_free_c && gnt_found_c) begin
            take_c[gnt_id_c] = 1'b1;
        end
    end

    // Output register holds steady while the consumer stalls
    always_ff @(posedge sysclk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_type  <= 2'b00;
            rr_ptr    <= '0;
        end else if (out_free_c) begin
            if (gnt_found_c) begin
                out_valid <= 1'b1;
                out_id    <= gnt_id_c;
                out_type  <= slot_type[gnt_id_c];
                rr_ptr    <= (gnt_id_c == IDW'(NBTN - 1)) ? '0 : gnt_id_c + IDW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign evt.evt_valid_o = out_valid;
    assign evt.evt_id_o    = out_id;
    assign evt.evt_type_o  = out_type;

endmodule
